// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze constants, food cell encoding and consumer state type
package maze_pkg;
  localparam int CELLS = 150;
  localparam int FOOD_NORMAL_BIT = 0;
  localparam int FOOD_RARE_BIT = 1;
  localparam int NORMAL_POINTS = 1;
  localparam int RARE_POINTS = 10;

  typedef enum logic [1:0] {
    S_WAIT,
    S_COUNT,
    S_PLAY,
    S_CLEAR
  } state_e;
endpackage

// File: rtl/food_consumer_if.sv
// rtl/food_consumer_if.sv - player move handshake between maze controller and food consumer
interface food_consumer_if;
  logic       move_valid;
  logic [7:0] move_pos;
  logic       move_ready;

  modport master (output move_valid, output move_pos, input move_ready);
  modport slave  (input move_valid, input move_pos, output move_ready);
endinterface

// File: rtl/food_consumer_sat_add.sv
// rtl/food_consumer_sat_add.sv - unsigned adder that clamps to all-ones on overflow
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    y_o = sum[W] ? '1 : sum[W-1:0];
  end
endmodule

// File: rtl/food_consumer.sv
// rtl/food_consumer.sv - counts generated food, eats it on player moves, tracks score and level clear
// Optional per-type eaten counters: FOOD_CONSUMER_STATS_EN
module food_consumer
  import maze_pkg::*;
#(
  parameter int CELLS         = maze_pkg::CELLS,
  parameter int NORMAL_POINTS = maze_pkg::NORMAL_POINTS,
  parameter int RARE_POINTS   = maze_pkg::RARE_POINTS,
  parameter int SCORE_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*CELLS-1:0]   food_i,
  input  logic                 gen_busy_i,
  food_consumer_if.slave       mv,
  output logic [2*CELLS-1:0]   food_visible_o,
  output logic [SCORE_W-1:0]   score_o,
  output logic [7:0]           remaining_o,
  output logic                 eat_pulse_o,
  output logic                 rare_pulse_o,
  output logic                 level_clear_o
`ifdef FOOD_CONSUMER_STATS_EN
  ,
  output logic [7:0]           eaten_normal_o,
  output logic [7:0]           eaten_rare_o
`endif
);
  localparam int IDX_W = $clog2(2 * CELLS);
  localparam logic [7:0] CELLS_B = 8'(CELLS);
  localparam logic [7:0] LAST_IDX = 8'(CELLS - 1);
  localparam logic [SCORE_W-1:0] NORMAL_P = SCORE_W'(NORMAL_POINTS);
  localparam logic [SCORE_W-1:0] RARE_P = SCORE_W'(RARE_POINTS);

  state_e               state_q;
  logic [7:0]           scan_idx_q;
  logic [7:0]           remaining_q;
  logic [CELLS-1:0]     eaten_q;
  logic [SCORE_W-1:0]   score_q;
  logic                 eat_pulse_q;
  logic                 rare_pulse_q;
  logic                 level_clear_q;
  logic                 move_ready_q;

  logic [IDX_W-1:0]     scan_base;
  logic [IDX_W-1:0]     move_base;
  logic [1:0]           scan_cell;
  logic [1:0]           move_cell;
  logic [7:0]           count_d;
  logic                 pos_ok;
  logic [7:0]           pos_sel;
  logic                 hit;
  logic                 is_rare;
  logic [SCORE_W-1:0]   points;
  logic [SCORE_W-1:0]   score_d;

  // Out-of-range positions are steered to cell 0 so indexing stays in bounds; pos_ok vetoes them.
  always_comb begin
    scan_base = IDX_W'({scan_idx_q, 1'b0});
    scan_cell = food_i[scan_base +: 2];
    count_d   = remaining_q + {7'b0, |scan_cell};
    pos_ok    = mv.move_pos < CELLS_B;
    pos_sel   = pos_ok ? mv.move_pos : 8'd0;
    move_base = IDX_W'({pos_sel, 1'b0});
    move_cell = food_i[move_base +: 2];
    is_rare   = move_cell[FOOD_RARE_BIT];
    hit       = mv.move_valid && pos_ok && !eaten_q[pos_sel] &&
                (move_cell[FOOD_NORMAL_BIT] | move_cell[FOOD_RARE_BIT]);
    points    = is_rare ? RARE_P : NORMAL_P;
  end

  sat_add #(.W(SCORE_W)) u_score (.a_i(score_q), .b_i(points), .y_o(score_d));

`ifdef FOOD_CONSUMER_STATS_EN
  logic [7:0] eaten_normal_q, eaten_rare_q, eaten_normal_d, eaten_rare_d;
  sat_add #(.W(8)) u_norm_cnt (.a_i(eaten_normal_q), .b_i(8'd1), .y_o(eaten_normal_d));
  sat_add #(.W(8)) u_rare_cnt (.a_i(eaten_rare_q), .b_i(8'd1), .y_o(eaten_rare_d));
  assign eaten_normal_o = eaten_normal_q;
  assign eaten_rare_o   = eaten_rare_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_WAIT;
      scan_idx_q    <= 8'd0;
      remaining_q   <= 8'd0;
      eaten_q       <= '0;
      score_q       <= '0;
      eat_pulse_q   <= 1'b0;
      rare_pulse_q  <= 1'b0;
      level_clear_q <= 1'b0;
      move_ready_q  <= 1'b0;
`ifdef FOOD_CONSUMER_STATS_EN
      eaten_normal_q <= 8'd0;
      eaten_rare_q   <= 8'd0;
`endif
    end else begin
      eat_pulse_q  <= 1'b0;
      rare_pulse_q <= 1'b0;
      case (state_q)
        S_WAIT: begin
          if (!gen_busy_i) state_q <= S_COUNT;
        end
        S_COUNT: begin
          scan_idx_q  <= scan_idx_q + 8'd1;
          remaining_q <= count_d;
          if (scan_idx_q == LAST_IDX) begin
            if (count_d != 8'd0) begin
              state_q      <= S_PLAY;
              move_ready_q <= 1'b1;
            end else begin
              state_q       <= S_CLEAR;
              level_clear_q <= 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (hit) begin
            eaten_q[pos_sel] <= 1'b1;
            remaining_q      <= remaining_q - 8'd1;
            score_q          <= score_d;
            rare_pulse_q     <= is_rare;
            eat_pulse_q      <= !is_rare;
`ifdef FOOD_CONSUMER_STATS_EN
            if (is_rare) eaten_rare_q <= eaten_rare_d;
            else eaten_normal_q <= eaten_normal_d;
`endif
            if (remaining_q == 8'd1) begin
              state_q       <= S_CLEAR;
              move_ready_q  <= 1'b0;
              level_clear_q <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          move_ready_q  <= 1'b0;
          level_clear_q <= 1'b1;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  always_comb begin
    food_visible_o = '0;
    for (int i = 0; i < CELLS; i++) begin
      food_visible_o[2*i +: 2] = food_i[2*i +: 2] & {2{~eaten_q[i]}};
    end
  end

  assign mv.move_ready   = move_ready_q;
  assign score_o         = score_q;
  assign remaining_o     = remaining_q;
  assign eat_pulse_o     = eat_pulse_q;
  assign rare_pulse_o    = rare_pulse_q;
  assign level_clear_o   = level_clear_q;
endmodule

// File: tb/tb_food_consumer.sv
// tb/tb_food_consumer.sv - scoreboard bench for food_consumer (16-bit and 4-bit score instances)
module tb_food_consumer;
  localparam int NC = 150;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [299:0]  food = '0;
  logic          gen_busy = 1'b1;

  food_consumer_if mv1 ();
  food_consumer_if mv2 ();
  assign mv2.move_valid = mv1.move_valid;
  assign mv2.move_pos   = mv1.move_pos;

  logic [299:0] vis1, vis2;
  logic [15:0]  score1;
  logic [3:0]   score2;
  logic [7:0]   rem1, rem2;
  logic         eat1, eat2, rare1, rare2, clr1, clr2;
`ifdef FOOD_CONSUMER_STATS_EN
  logic [7:0]   en1, er1, en2, er2;
`endif

  always #5 clk = ~clk;

  food_consumer #(.SCORE_W(16)) dut (
    .clk(clk), .rst(rst), .food_i(food), .gen_busy_i(gen_busy), .mv(mv1.slave),
    .food_visible_o(vis1), .score_o(score1), .remaining_o(rem1),
    .eat_pulse_o(eat1), .rare_pulse_o(rare1), .level_clear_o(clr1)
`ifdef FOOD_CONSUMER_STATS_EN
    , .eaten_normal_o(en1), .eaten_rare_o(er1)
`endif
  );

  food_consumer #(.SCORE_W(4)) dut4 (
    .clk(clk), .rst(rst), .food_i(food), .gen_busy_i(gen_busy), .mv(mv2.slave),
    .food_visible_o(vis2), .score_o(score2), .remaining_o(rem2),
    .eat_pulse_o(eat2), .rare_pulse_o(rare2), .level_clear_o(clr2)
`ifdef FOOD_CONSUMER_STATS_EN
    , .eaten_normal_o(en2), .eaten_rare_o(er2)
`endif
  );

  typedef struct {
    bit rare;
    int score;
    int rem;
    int pos;
  } exp_t;
  exp_t sbq[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what the player has done so far, in plain terms.
  bit [299:0] m_food;
  bit         m_eaten[NC];
  int         m_score, m_score4, m_rem, m_en, m_er;
  bit         m_play, m_clear;
  int         occ[$];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vis(input string name, input logic [299:0] act, input logic [299:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [299:0] model_vis();
    logic [299:0] v;
    for (int i = 0; i < NC; i++) v[2*i +: 2] = m_eaten[i] ? 2'b00 : m_food[2*i +: 2];
    return v;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(negedge clk) begin
    if (!rst && (eat1 || rare1)) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got eat=%0d rare=%0d expected none", eat1, rare1);
      end else begin
        exp_t e;
        logic [299:0] v;
        e = sbq.pop_front();
        v = vis1;
        check("sb_rare_pulse", rare1, e.rare);
        check("sb_eat_pulse", eat1, !e.rare);
        check("sb_score", score1, e.score);
        check("sb_remaining", rem1, e.rem);
        check("sb_cell_hidden", v[2*e.pos +: 2], 0);
      end
    end
    if (!rst) begin
      check("pulses_match_dut4", {eat2, rare2}, {eat1, rare1});
    end
  end

  task automatic restart(input logic [299:0] map, input bit poke);
    int cycles;
    @(posedge clk); #1;
    rst = 1'b1; gen_busy = 1'b1; food = map;
    mv1.move_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_food = map; m_score = 0; m_score4 = 0; m_en = 0; m_er = 0;
    m_play = 0; m_clear = 0; m_rem = 0;
    occ.delete();
    for (int i = 0; i < NC; i++) begin
      m_eaten[i] = 0;
      if (map[2*i] | map[2*i+1]) occ.push_back(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_score", score1, 0);
    check("rst_remaining", rem1, 0);
    check("rst_ready", mv1.move_ready, 0);
    check("rst_clear", clr1, 0);
    check_vis("rst_visible", vis1, map);
    @(posedge clk); #1;
    gen_busy = 1'b0;
    if (poke) begin
      mv1.move_valid = 1'b1;
      mv1.move_pos = 8'd5;
    end
    cycles = 0;
    while (cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 100) mv1.move_valid = 1'b0;
      @(negedge clk);
      if (mv1.move_ready || clr1) break;
    end
    mv1.move_valid = 1'b0;
    m_rem = occ.size();
    m_play = (m_rem > 0);
    m_clear = !m_play;
    check("count_latency", cycles, 151);
    check("count_remaining", rem1, m_rem);
    check("count_remaining4", rem2, m_rem);
    check("count_score", score1, 0);
    check("count_ready", mv1.move_ready, m_play);
    check("count_clear", clr1, m_clear);
    check("count_clear4", clr2, m_clear);
    check("count_sb_empty", sbq.size(), 0);
  endtask

  task automatic do_move(input int pos);
    @(posedge clk); #1;
    mv1.move_valid = 1'b1;
    mv1.move_pos = 8'(pos);
    if (m_play && pos < NC && !m_eaten[pos] && (m_food[2*pos] | m_food[2*pos+1])) begin
      exp_t e;
      bit r;
      r = m_food[2*pos+1];
      m_eaten[pos] = 1;
      m_rem--;
      m_score = sat(m_score + (r ? 10 : 1), 65535);
      m_score4 = sat(m_score4 + (r ? 10 : 1), 15);
      if (r) m_er = sat(m_er + 1, 255); else m_en = sat(m_en + 1, 255);
      e.rare = r; e.score = m_score; e.rem = m_rem; e.pos = pos;
      sbq.push_back(e);
      if (m_rem == 0) begin
        m_play = 0;
        m_clear = 1;
      end
    end
    @(posedge clk); #1;
    mv1.move_valid = 1'b0;
    @(negedge clk);
    check("mv_score", score1, m_score);
    check("mv_score4", score2, m_score4);
    check("mv_remaining", rem1, m_rem);
    check("mv_remaining4", rem2, m_rem);
    check("mv_ready", mv1.move_ready, m_play);
    check("mv_clear", clr1, m_clear);
    check_vis("mv_visible", vis1, model_vis());
`ifdef FOOD_CONSUMER_STATS_EN
    check("mv_eaten_normal", en1, m_en);
    check("mv_eaten_rare", er1, m_er);
    check("mv_eaten_normal4", en2, m_en);
    check("mv_eaten_rare4", er2, m_er);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [299:0] map;
    mv1.move_valid = 1'b0;
    mv1.move_pos = 8'd0;

    // Directed: normal at 0 and 149, rare at 5; moves during COUNT are dropped.
    map = '0; map[0] = 1'b1; map[11] = 1'b1; map[298] = 1'b1;
    restart(map, 1);
    do_move(5);
    do_move(5);
    do_move(200);
    do_move(150);
    do_move(0);
    do_move(149);
    do_move(0);

    // Empty map clears straight after counting.
    restart('0, 0);
    do_move(3);

    // Rare cells 1..3 push the 4-bit score into saturation; cell 4 carries both bits.
    map = '0; map[3] = 1'b1; map[5] = 1'b1; map[7] = 1'b1; map[8] = 1'b1; map[9] = 1'b1;
    restart(map, 0);
    do_move(1);
    do_move(2);
    do_move(4);
    do_move(3);

    // Random maps; even rounds are cut short by a reset mid-play.
    for (int r = 0; r < 6; r++) begin
      map = '0;
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 9) < 4) map[2*i +: 2] = 2'($urandom_range(1, 3));
      end
      restart(map, r == 1);
      for (int k = 0; k < 40; k++) begin
        int p;
        case ($urandom_range(0, 3))
          0: p = $urandom_range(150, 255);
          1: p = $urandom_range(0, 149);
          default: p = (occ.size() > 0) ? occ[$urandom_range(0, occ.size() - 1)] : 0;
        endcase
        do_move(p);
      end
      if (r % 2 == 1) begin
        for (int i = 0; i < NC; i++) begin
          if (!m_eaten[i] && (m_food[2*i] | m_food[2*i+1])) do_move(i);
        end
        do_move(0);
      end
    end

    restart(map, 0);
    @(negedge clk);
    check("final_sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/food_consumer.md
Name: food_consumer

Overview:
- Consumer side of the maze food map. Waits for the food generator to finish filling the 300-bit map (150 cells, 2 bits per cell: bit 2i = normal, bit 2i+1 = rare), then counts the occupied cells.
- Then accepts player-move events: eats the food at the visited cell, accumulates score, and flags level clear when no food remains.
- Sits between the food generator and the renderer/score display. It keeps its own eaten mask, so the generator's map is never written back.

Parameters:
- CELLS, 150, number of maze cells; map width is 2*CELLS.
- NORMAL_POINTS, 1, score added for a normal food.
- RARE_POINTS, 10, score added for a rare food.
- SCORE_W, 16, score register width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- food  in  300  generator map; bit 2i normal, bit 2i+1 rare
- gen_busy  in  1  generator still filling the map
- move_valid  in  1  player entered cell move_pos this cycle
- move_pos  in  8  cell index 0..CELLS-1
- move_ready  out  1  move accepted this cycle (high only in PLAY)
- food_visible  out  300  food with eaten cells masked to 00 (combinational from food and the eaten mask)
- score  out  SCORE_W  accumulated score, saturating
- remaining  out  8  uneaten occupied cells
- eat_pulse  out  1  one-cycle pulse, normal food eaten
- rare_pulse  out  1  one-cycle pulse, rare food eaten
- level_clear  out  1  level-clear flag; stays high until rst

Behaviour:
- Reset values: state WAIT, eaten mask 0, score 0, remaining 0, scan_idx 0, all pulses 0, level_clear 0, move_ready 0.
- rst is shared with the generator. rst mid-operation returns to WAIT with all state cleared.
- State WAIT: move_ready=0. Go to COUNT on the first cycle after reset with gen_busy=0.
- State COUNT: one cell per cycle, scan_idx 0..CELLS-1.
  - remaining += 1 if food[2i] | food[2i+1].
  - After scan_idx=CELLS-1 (CELLS cycles), go to PLAY if the final count is nonzero, else to CLEAR.
  - Moves arriving in WAIT/COUNT are dropped (move_ready=0); there is no buffering.
- State PLAY: move_ready=1.
  - On move_valid, with move_pos < CELLS, cell not eaten, and food nonzero, all results are registered and visible the next cycle:
    - set eaten[move_pos];
    - decrement remaining;
    - if the rare bit is set (takes priority when both bits are set): score += RARE_POINTS and rare_pulse=1;
    - otherwise: score += NORMAL_POINTS and eat_pulse=1.
  - A move to an already-eaten cell, an empty cell, or move_pos >= CELLS produces no change and no pulse.
  - score saturates at 2^SCORE_W-1.
  - When remaining goes 1->0, enter CLEAR in the same update; level_clear=1 from the next cycle.
- State CLEAR: move_ready=0 and level_clear=1. Hold until rst.
- Changes to food after WAIT are not re-counted. food_visible still reflects the live food map ANDed with ~eaten.

Optional Feature:
- Macro: FOOD_CONSUMER_STATS_EN.
- Defined: adds output ports eaten_normal[7:0] and eaten_rare[7:0]. These are per-type eaten counters, reset to 0, incremented alongside eat_pulse / rare_pulse, and saturating at 255.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package maze_pkg holds:
  - CELLS;
  - FOOD_NORMAL_BIT=0 and FOOD_RARE_BIT=1 (the 2-bit cell encoding);
  - NORMAL_POINTS and RARE_POINTS defaults;
  - the state enum WAIT/COUNT/PLAY/CLEAR.
- One sub-module, sat_add: parameterised-width saturating adder used for score (and the stats counters). The rest stays in a single module.

Test Plan:
- Reset, generator fills a map with cells 0 (normal), 5 (rare), 149 (normal) and the rest empty -> after gen_busy falls, 150 COUNT cycles, then PLAY with remaining=3, score=0, move_ready=1.
- Move to 5 -> next cycle score=10, rare_pulse=1 for one cycle, remaining=2, food_visible[11:10]=00. Move to 5 again -> no change, no pulse.
- Moves to 0 then 149 -> score=12, eat_pulse twice, remaining=0, level_clear=1, move_ready=0. A further move to 0 is ignored.
- move_pos=200 and move_pos=150 in PLAY -> no state change. move_valid during COUNT -> dropped, and score stays 0 after PLAY is entered.
- All-empty map -> CLEAR right after COUNT, level_clear=1, remaining=0. SCORE_W=4 with two rare cells eaten -> score saturates at 15.
- rst asserted mid-PLAY after one eat -> score=0, eaten mask cleared, state WAIT, full recount. With FOOD_CONSUMER_STATS_EN, eaten_rare and eaten_normal match the pulse counts.
